// File: rtl/cache_control.sv
// ---------------------------------------------------------------------------
// cache_control
//   Sequencing FSM for a 2-way set-associative L1 cache datapath
//   (8 sets, 32-byte lines, s_tag-bit tags). Decodes CPU requests, resolves
//   hits across both ways, and steers the datapath array strobes. It also
//   drives physical memory for dirty-victim writeback and line refill.
//
//   Optional feature: define CACHE_PERF_CNT_EN to add hit/miss/writeback
//   performance counters (ports hit_count, miss_count, wb_count).
//
// Ports
//   clk, rst                  clock, async active-low reset
//   mem_read/mem_write        CPU request (held until mem_resp)
//   mem_tag                   request tag (address[31:8])
//   mem_resp                  1-cycle completion pulse to CPU
//   pmem_read/pmem_write      line transfer to memory (held until pmem_resp)
//   pmem_resp                 memory completion
//   tag1/2, valid1/2, dirty1/2, lru   datapath array outputs for the set
//   read_en                   datapath array read enable
//   load_tag/valid/dirty, valid_in, dirty_in   per-way array writes ([0] way1)
//   load_lru, lru_input       LRU update (lru_input = way touched)
//   data1/2_in_sel            0: pmem_rdata, 1: bus_wdata
//   way1/2_wr_sel             00 none, 01 full line, 10 byte-enable
//   pmem_mux_sel              00 request, 01 way1 victim, 10 way2 victim
//   cache_out_sel             0 way1, 1 way2
//   hit_count/miss_count/wb_count   perf counters (CACHE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module cache_control #(
  parameter int s_tag = 24,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [s_tag-1:0] mem_tag,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic [s_tag-1:0] tag1,
  input  logic [s_tag-1:0] tag2,
  input  logic             valid1,
  input  logic             valid2,
  input  logic             dirty1,
  input  logic             dirty2,
  input  logic             lru,
  output logic             read_en,
  output logic [1:0]       load_tag,
  output logic [1:0]       load_valid,
  output logic [1:0]       load_dirty,
  output logic [1:0]       valid_in,
  output logic [1:0]       dirty_in,
  output logic             load_lru,
  output logic             lru_input,
  output logic             data1_in_sel,
  output logic             data2_in_sel,
  output logic [1:0]       way1_wr_sel,
  output logic [1:0]       way2_wr_sel,
  output logic [1:0]       pmem_mux_sel,
  output logic             cache_out_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
`endif
);

  if (s_tag < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("cache_control: s_tag and CNT_W must be positive");
  end

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COMPARE   = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_ALLOCATE  = 3'd3;
  localparam logic [2:0] S_REFILL    = 3'd4;

  logic [2:0] state_q, state_d;

  logic       req, is_wr;
  logic       hit1, hit2, hit, hit_w2, victim_w2, victim_dirty;
  logic [1:0] hit_mask, vic_mask;

  // Simultaneous read+write is treated as a write.
  assign req   = mem_read | mem_write;
  assign is_wr = mem_write;

  assign hit1   = valid1 && (tag1 == mem_tag);
  assign hit2   = valid2 && (tag2 == mem_tag);
  assign hit    = hit1 | hit2;
  // Way1 wins when both ways report a hit.
  assign hit_w2 = ~hit1 & hit2;

  // lru names the most recently used way, so the victim is the other one.
  assign victim_w2    = ~lru;
  assign victim_dirty = victim_w2 ? (valid2 & dirty2) : (valid1 & dirty1);

  assign hit_mask = hit_w2    ? 2'b10 : 2'b01;
  assign vic_mask = victim_w2 ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // IDLE drives no strobes, so the async reset of state_q alone forces every
  // strobe low immediately; read_en is the only output gated directly.
  always_comb begin
    state_d       = state_q;
    read_en       = rst;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_tag      = 2'b00;
    load_valid    = 2'b00;
    load_dirty    = 2'b00;
    valid_in      = 2'b00;
    dirty_in      = 2'b00;
    load_lru      = 1'b0;
    lru_input     = 1'b0;
    data1_in_sel  = 1'b0;
    data2_in_sel  = 1'b0;
    way1_wr_sel   = 2'b00;
    way2_wr_sel   = 2'b00;
    pmem_mux_sel  = 2'b00;
    cache_out_sel = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (hit) begin
          mem_resp      = 1'b1;
          cache_out_sel = hit_w2;
          load_lru      = 1'b1;
          lru_input     = hit_w2;
          if (is_wr) begin
            if (hit_w2) begin
              way2_wr_sel  = 2'b10;
              data2_in_sel = 1'b1;
            end else begin
              way1_wr_sel  = 2'b10;
              data1_in_sel = 1'b1;
            end
            load_dirty = hit_mask;
            dirty_in   = hit_mask;
          end
          state_d = S_IDLE;
        end else begin
          state_d = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_mux_sel  = victim_w2 ? 2'b10 : 2'b01;
        cache_out_sel = victim_w2;
        if (pmem_resp) begin
          load_dirty = vic_mask;
          state_d    = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          if (victim_w2) way2_wr_sel = 2'b01;
          else           way1_wr_sel = 2'b01;
          load_tag   = vic_mask;
          load_valid = vic_mask;
          valid_in   = vic_mask;
          load_dirty = vic_mask;
          state_d    = S_REFILL;
        end
      end
      // One settle cycle so the arrays present the new line before re-compare.
      S_REFILL: state_d = S_COMPARE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  // Set after a miss so the re-compare hit that completes it is not a hit.
  logic             miss_seen_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      miss_seen_q <= 1'b0;
    end else begin
      if (state_q == S_COMPARE) begin
        if (!req) begin
          miss_seen_q <= 1'b0;
        end else if (hit) begin
          if (!miss_seen_q) hit_cnt_q <= hit_cnt_q + 1'b1;
          miss_seen_q <= 1'b0;
        end else begin
          miss_cnt_q  <= miss_cnt_q + 1'b1;
          miss_seen_q <= 1'b1;
        end
      end
      if (state_q == S_WRITEBACK && pmem_resp) wb_cnt_q <= wb_cnt_q + 1'b1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: a behavioural datapath array model and a memory
// responder surround the DUT. Stimulus pushes expected events into a queue
// and a monitor compares each mem_resp / pmem completion it sees.
module tb_cache_control;
  logic        clk = 1'b0, rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, pmem_resp = 1'b0;
  logic [23:0] mem_tag = '0;
  logic        mem_resp, pmem_read, pmem_write, read_en, load_lru, lru_input;
  logic        data1_in_sel, data2_in_sel, cache_out_sel;
  logic [1:0]  load_tag, load_valid, load_dirty, valid_in, dirty_in;
  logic [1:0]  way1_wr_sel, way2_wr_sel, pmem_mux_sel;
  logic [23:0] tag1, tag2;
  logic        valid1, valid2, dirty1, dirty2, lru;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  int tests = 0, fails = 0;
  int cur_set = 0;
  logic [22:0] expq [$];

  logic [23:0] tagm [8][2] = '{default: '0};
  logic        vm   [8][2] = '{default: 1'b0};
  logic        dm   [8][2] = '{default: 1'b0};
  logic        lrum [8]    = '{default: 1'b0};

  always #5 clk = ~clk;

  cache_control #(.s_tag(24), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_tag(mem_tag), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .tag1(tag1), .tag2(tag2),
    .valid1(valid1), .valid2(valid2), .dirty1(dirty1), .dirty2(dirty2),
    .lru(lru), .read_en(read_en), .load_tag(load_tag), .load_valid(load_valid),
    .load_dirty(load_dirty), .valid_in(valid_in), .dirty_in(dirty_in),
    .load_lru(load_lru), .lru_input(lru_input), .data1_in_sel(data1_in_sel),
    .data2_in_sel(data2_in_sel), .way1_wr_sel(way1_wr_sel),
    .way2_wr_sel(way2_wr_sel), .pmem_mux_sel(pmem_mux_sel),
    .cache_out_sel(cache_out_sel)
`ifdef CACHE_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );

  // Datapath arrays for the currently addressed set.
  assign tag1   = tagm[cur_set][0];
  assign tag2   = tagm[cur_set][1];
  assign valid1 = vm[cur_set][0];
  assign valid2 = vm[cur_set][1];
  assign dirty1 = dm[cur_set][0];
  assign dirty2 = dm[cur_set][1];
  assign lru    = lrum[cur_set];

  always @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < 2; w++) begin
        if (load_tag[w])   tagm[cur_set][w] <= mem_tag;
        if (load_valid[w]) vm[cur_set][w]   <= valid_in[w];
        if (load_dirty[w]) dm[cur_set][w]   <= dirty_in[w];
      end
      if (load_lru) lrum[cur_set] <= lru_input;
    end
  end

  // Memory: pmem_resp one cycle wide, MEM_LAT cycles after a request starts.
  localparam int MEM_LAT = 2;
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end else if (rst && (pmem_read || pmem_write)) begin
        cnt++;
        if (cnt >= MEM_LAT) pmem_resp = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Event vector: {kind, mux, cos, w1, w2, d1, d2, ltag, lval, vin, ldir, din, llru, lin}
  // kind 1 = mem_resp, 2 = refill completion, 3 = writeback completion.
  function automatic logic [22:0] ev(input logic [1:0] kind, mux, input logic cos,
      input logic [1:0] w1, w2, input logic d1, d2,
      input logic [1:0] ltag, lval, vin, ldir, din, input logic llru, lin);
    return {kind, mux, cos, w1, w2, d1, d2, ltag, lval, vin, ldir, din, llru, lin};
  endfunction

  task automatic exp_fill(input logic w2);
    logic [1:0] m;
    m = w2 ? 2'b10 : 2'b01;
    expq.push_back(ev(2'd2, 2'b00, 1'b0, w2 ? 2'b00 : 2'b01, w2 ? 2'b01 : 2'b00,
                      1'b0, 1'b0, m, m, m, m, 2'b00, 1'b0, 1'b0));
  endtask

  task automatic exp_wb(input logic w2);
    logic [1:0] m;
    m = w2 ? 2'b10 : 2'b01;
    expq.push_back(ev(2'd3, m, w2, 2'b00, 2'b00, 1'b0, 1'b0,
                      2'b00, 2'b00, 2'b00, m, 2'b00, 1'b0, 1'b0));
  endtask

  task automatic exp_resp(input logic w2, input logic wr);
    logic [1:0] m;
    m = w2 ? 2'b10 : 2'b01;
    expq.push_back(ev(2'd1, 2'b00, w2, (wr && !w2) ? 2'b10 : 2'b00,
                      (wr && w2) ? 2'b10 : 2'b00, wr && !w2, wr && w2,
                      2'b00, 2'b00, 2'b00, wr ? m : 2'b00, wr ? m : 2'b00, 1'b1, w2));
  endtask

  // Monitor: compares every observed completion against the queue head.
  initial begin
    logic [1:0]  kind;
    logic [22:0] got, want;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pmem_read || pmem_write) chk("pmem_excl", {30'd0, pmem_read, pmem_write}, pmem_read ? 32'd2 : 32'd1);
        kind = mem_resp ? 2'd1 : (pmem_read && pmem_resp) ? 2'd2 :
               (pmem_write && pmem_resp) ? 2'd3 : 2'd0;
        if (kind != 2'd0) begin
          got = ev(kind, pmem_mux_sel, cache_out_sel, way1_wr_sel, way2_wr_sel,
                   data1_in_sel, data2_in_sel, load_tag, load_valid, valid_in,
                   load_dirty, dirty_in, load_lru, lru_input);
          if (expq.size() == 0) begin
            chk("unexpected_event", {9'd0, got}, 32'd0);
          end else begin
            want = expq.pop_front();
            chk("event", {9'd0, got}, {9'd0, want});
          end
        end
      end
    end
  end

  // Issue one request and wait (bounded) for mem_resp; latency in negedges.
  task automatic req(input int s, input logic [23:0] t, input logic rd, wr,
                     input int exp_lat, input string name);
    int  cyc = 0;
    bit  got = 0;
    @(posedge clk); #1;
    cur_set = s; mem_tag = t; mem_read = rd; mem_write = wr;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_resp) got = 1;
    end
    chk({name, "_latency"}, cyc, exp_lat);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cyc;
    #2;
    chk("rst_read_en", read_en, 0);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem", {pmem_read, pmem_write}, 0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_counters", hit_count | miss_count | wb_count, 0);
`endif
    @(posedge clk); #1; rst = 1'b1;
    #1 chk("read_en_active", read_en, 1);

    // Cold read set 3: allocate into way2 (lru=0), then hit.
    exp_fill(1'b1); exp_resp(1'b1, 1'b0);
    req(3, 24'h00ABCD, 1, 0, 6, "cold_read");
    chk("valid2_set3", vm[3][1], 1);
    chk("tag2_set3", tagm[3][1], 32'h00ABCD);
    // Repeat read: pure hit.
    exp_resp(1'b1, 1'b0);
    req(3, 24'h00ABCD, 1, 0, 2, "read_hit_w2");
    // lru=1 -> way1 victim (invalid) for a second tag.
    exp_fill(1'b0); exp_resp(1'b0, 1'b0);
    req(3, 24'h000111, 1, 0, 6, "fill_way1");
    // Write hit way1.
    exp_resp(1'b0, 1'b1);
    req(3, 24'h000111, 0, 1, 2, "write_hit_w1");
    chk("dirty1_set", dm[3][0], 1);
    // Touch way2 so way1 (dirty) becomes victim.
    exp_resp(1'b1, 1'b0);
    req(3, 24'h00ABCD, 1, 0, 2, "touch_w2");
    exp_wb(1'b0); exp_fill(1'b0); exp_resp(1'b0, 1'b0);
    req(3, 24'h0F0F0F, 1, 0, 9, "dirty_miss");
    chk("dirty1_clear", dm[3][0], 0);
    chk("tag1_new", tagm[3][0], 32'h0F0F0F);
    // Read+write together behaves as a write.
    exp_resp(1'b0, 1'b1);
    req(3, 24'h0F0F0F, 1, 1, 2, "rw_as_write");
    chk("dirty1_rw", dm[3][0], 1);

    // Request dropped in COMPARE: no response, no memory traffic.
    @(posedge clk); #1; cur_set = 3; mem_tag = 24'h0DEAD0; mem_read = 1'b1;
    @(posedge clk); #1; mem_read = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("drop_no_pmem", {pmem_read, pmem_write}, 0);
    chk("drop_queue", expq.size(), 0);
    exp_resp(1'b0, 1'b0);
    req(3, 24'h0F0F0F, 1, 0, 2, "after_drop");

    // Reset in the middle of ALLOCATE.
    @(posedge clk); #1; cur_set = 5; mem_tag = 24'h123456; mem_read = 1'b1;
    cyc = 0;
    while (!pmem_read && cyc < 20) begin @(negedge clk); cyc++; end
    chk("alloc_reached", pmem_read, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_pmem_read", pmem_read, 0);
    chk("rst_mid_read_en", read_en, 0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_mid_no_fill", vm[5][1], 0);

    // Post-reset: 1 cold miss, 3 hits, 1 dirty miss.
    exp_fill(1'b1); exp_resp(1'b1, 1'b0);
    req(5, 24'h123456, 1, 0, 6, "post_rst_cold");
    for (int i = 0; i < 3; i++) begin
      exp_resp(1'b1, 1'b0);
      req(3, 24'h00ABCD, 1, 0, 2, "perf_hit");
    end
    exp_wb(1'b0); exp_fill(1'b0); exp_resp(1'b0, 1'b0);
    req(3, 24'h777777, 1, 0, 9, "perf_dirty_miss");
`ifdef CACHE_PERF_CNT_EN
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 2);
    chk("wb_count", wb_count, 1);
`endif
    repeat (2) @(posedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
